// File: rtl/riscv_immdec_pipe_pkg.sv
// Shared definitions for the pipelined immediate decoder.
// The immediate-format select codes live here so that the decode stage and
// any instruction predecoder agree on one encoding.
package riscv_immdec_pipe_pkg;

    localparam int IMM_SRC_W = 3;

    // Immediate format select codes
    localparam logic [IMM_SRC_W-1:0] SRC_IMM_I   = 3'd0;
    localparam logic [IMM_SRC_W-1:0] SRC_IMM_S   = 3'd1;
    localparam logic [IMM_SRC_W-1:0] SRC_IMM_B   = 3'd2;
    localparam logic [IMM_SRC_W-1:0] SRC_IMM_U   = 3'd3;
    localparam logic [IMM_SRC_W-1:0] SRC_IMM_J   = 3'd4;
    localparam logic [IMM_SRC_W-1:0] SRC_IMM_Z   = 3'd5;   // CSR zimm (uimm[4:0])
    localparam logic [IMM_SRC_W-1:0] SRC_IMM_SH  = 3'd6;   // shift amount
    localparam logic [IMM_SRC_W-1:0] SRC_IMM_ILL = 3'd7;   // unsupported

    // Sign-extend a 32-bit value to 64 bits; narrower datapaths truncate.
    function automatic logic [63:0] sext32(input logic [31:0] val);
        sext32 = {{32{val[31]}}, val};
    endfunction

endpackage

// File: rtl/riscv_immdec_fmt.sv
// Purely combinational immediate extraction for one instruction word.
// Every format is first built as a 32-bit value and then widened, so the same
// field logic serves XLEN=32 and XLEN=64.
module riscv_immdec_fmt
    import riscv_immdec_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]          instr,
    input  logic [IMM_SRC_W-1:0] src,
    output logic [XLEN-1:0]      imm,
    output logic                 err
);

    logic [63:0] imm_i64;
    logic [63:0] imm_s64;
    logic [63:0] imm_b64;
    logic [63:0] imm_u64;
    logic [63:0] imm_j64;
    logic [63:0] imm_z64;
    logic [63:0] imm_sh64;

    // Opcode bits never contribute to any immediate.
    logic unused_opcode;
    assign unused_opcode = ^instr[6:0];

    // Field extraction for every format in parallel; the select below picks one.
    always_comb begin
        imm_i64  = sext32({{20{instr[31]}}, instr[31:20]});
        imm_s64  = sext32({{20{instr[31]}}, instr[31:25], instr[11:7]});
        imm_b64  = sext32({{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                           instr[11:8], 1'b0});
        imm_u64  = sext32({instr[31:12], 12'b0});
        imm_j64  = sext32({{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                           instr[30:21], 1'b0});
        imm_z64  = {59'b0, instr[19:15]};
        // RV64 shifts use a 6-bit shamt; RV32 only 5 bits.
        if (XLEN == 64) begin
            imm_sh64 = {58'b0, instr[25:20]};
        end else begin
            imm_sh64 = {59'b0, instr[24:20]};
        end
    end

    // Format select; unsupported codes yield a zero immediate and flag an error.
    always_comb begin
        imm = '0;
        err = 1'b0;
        case (src)
            SRC_IMM_I:  imm = imm_i64[XLEN-1:0];
            SRC_IMM_S:  imm = imm_s64[XLEN-1:0];
            SRC_IMM_B:  imm = imm_b64[XLEN-1:0];
            SRC_IMM_U:  imm = imm_u64[XLEN-1:0];
            SRC_IMM_J:  imm = imm_j64[XLEN-1:0];
            SRC_IMM_Z:  imm = imm_z64[XLEN-1:0];
            SRC_IMM_SH: imm = imm_sh64[XLEN-1:0];
            default: begin
                imm = '0;
                err = 1'b1;
            end
        endcase
    end

    // The upper half of the 64-bit intermediates is dropped when XLEN=32.
    logic unused_upper;
    assign unused_upper = ^{imm_i64, imm_s64, imm_b64, imm_u64, imm_j64,
                            imm_z64, imm_sh64};

endmodule

// File: rtl/riscv_immdec_pipe.sv
// Registered immediate decoder with valid/ready on both sides.
// Two storage entries: OUT drives the outputs, SKID absorbs the one extra
// instruction that can arrive while OUT is stalled, so o_ready is a pure flop.
module riscv_immdec_pipe
    import riscv_immdec_pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_flush,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [31:0]          i_imm_instr,
    input  logic [IMM_SRC_W-1:0] i_imm_src,
    input  logic [TAG_W-1:0]     i_tag,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [XLEN-1:0]      o_imm_dec,
    output logic                 o_imm_err,
    output logic [TAG_W-1:0]     o_tag
);

    logic [XLEN-1:0]  dec_imm;
    logic             dec_err;

    logic             out_valid_q,  out_valid_d;
    logic [XLEN-1:0]  out_imm_q,    out_imm_d;
    logic             out_err_q,    out_err_d;
    logic [TAG_W-1:0] out_tag_q,    out_tag_d;

    logic             skid_valid_q, skid_valid_d;
    logic [XLEN-1:0]  skid_imm_q,   skid_imm_d;
    logic             skid_err_q,   skid_err_d;
    logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;

    logic             ready_q,      ready_d;

    logic             accept;
    logic             fire;

    riscv_immdec_fmt #(
        .XLEN (XLEN)
    ) u_fmt (
        .instr (i_imm_instr),
        .src   (i_imm_src),
        .imm   (dec_imm),
        .err   (dec_err)
    );

    assign accept = i_valid & ready_q;
    assign fire   = out_valid_q & i_ready;

    // Next-state for OUT/SKID: flush wins, then skid drain, then fill.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_imm_d    = out_imm_q;
        out_err_d    = out_err_q;
        out_tag_d    = out_tag_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_err_d   = skid_err_q;
        skid_tag_d   = skid_tag_q;

        if (i_flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (fire && skid_valid_q) begin
            // o_ready is low whenever SKID holds data, so no accept here.
            out_valid_d  = 1'b1;
            out_imm_d    = skid_imm_q;
            out_err_d    = skid_err_q;
            out_tag_d    = skid_tag_q;
            skid_valid_d = 1'b0;
        end else if (accept && (!out_valid_q || fire)) begin
            out_valid_d  = 1'b1;
            out_imm_d    = dec_imm;
            out_err_d    = dec_err;
            out_tag_d    = i_tag;
        end else if (accept) begin
            // OUT is stalled: park the new instruction in SKID.
            skid_valid_d = 1'b1;
            skid_imm_d   = dec_imm;
            skid_err_d   = dec_err;
            skid_tag_d   = i_tag;
        end else if (fire) begin
            out_valid_d  = 1'b0;
        end

        ready_d = ~skid_valid_d;
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_err_q    <= 1'b0;
            out_tag_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_err_q   <= 1'b0;
            skid_tag_q   <= '0;
            ready_q      <= 1'b1;
        end else begin
            out_valid_q  <= out_valid_d;
            out_imm_q    <= out_imm_d;
            out_err_q    <= out_err_d;
            out_tag_q    <= out_tag_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_err_q   <= skid_err_d;
            skid_tag_q   <= skid_tag_d;
            ready_q      <= ready_d;
        end
    end

    assign o_ready   = ready_q;
    assign o_valid   = out_valid_q;
    assign o_imm_dec = out_imm_q;
    assign o_imm_err = out_err_q;
    assign o_tag     = out_tag_q;

endmodule

// File: tb/tb_riscv_immdec_pipe.sv
// Directed bench for riscv_immdec_pipe: one XLEN=32 and one XLEN=64 instance
// share the same input stimulus; outputs are checked 1 time unit after each
// rising edge against hand-computed values.
module tb_riscv_immdec_pipe;

    localparam int TAG_W = 8;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic [31:0]      instr;
    logic [2:0]       src;
    logic [TAG_W-1:0] tag;
    logic             out_ready;

    logic             rdy32,  vld32,  err32;
    logic [31:0]      imm32;
    logic [TAG_W-1:0] tag32;
    logic             rdy64,  vld64,  err64;
    logic [63:0]      imm64;
    logic [TAG_W-1:0] tag64;

    int checks;
    int errors;

    riscv_immdec_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_flush     (flush),
        .i_valid     (in_valid),
        .o_ready     (rdy32),
        .i_imm_instr (instr),
        .i_imm_src   (src),
        .i_tag       (tag),
        .o_valid     (vld32),
        .i_ready     (out_ready),
        .o_imm_dec   (imm32),
        .o_imm_err   (err32),
        .o_tag       (tag32)
    );

    riscv_immdec_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_flush     (flush),
        .i_valid     (in_valid),
        .o_ready     (rdy64),
        .i_imm_instr (instr),
        .i_imm_src   (src),
        .i_tag       (tag),
        .o_valid     (vld64),
        .i_ready     (out_ready),
        .o_imm_dec   (imm64),
        .o_imm_err   (err64),
        .o_tag       (tag64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", name, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", name, got);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] w, input logic [2:0] s,
                         input logic [TAG_W-1:0] t);
        in_valid = v;
        instr    = w;
        src      = s;
        tag      = t;
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_vld32"}, 64'(vld32), 64'd0);
        check({name, "_rdy32"}, 64'(rdy32), 64'd1);
        check({name, "_imm32"}, 64'(imm32), 64'd0);
        check({name, "_err32"}, 64'(err32), 64'd0);
        check({name, "_tag32"}, 64'(tag32), 64'd0);
        check({name, "_vld64"}, 64'(vld64), 64'd0);
        check({name, "_rdy64"}, 64'(rdy64), 64'd1);
        check({name, "_imm64"}, imm64,      64'd0);
        check({name, "_tag64"}, 64'(tag64), 64'd0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'h0, 3'd0, 8'h00);
        step();
        step();
        rst = 1'b0;
        check_reset_state("reset");

        // Back-to-back stream, downstream always ready.
        drive(1'b1, 32'hFFF00093, 3'd0, 8'h01);
        step();
        check("i_vld",   64'(vld32), 64'd1);
        check("i_imm32", 64'(imm32), 64'hFFFFFFFF);
        check("i_imm64", imm64,      64'hFFFFFFFFFFFFFFFF);
        check("i_tag",   64'(tag32), 64'h01);
        drive(1'b1, 32'hFE112E23, 3'd1, 8'h02);
        step();
        check("s_vld",   64'(vld32), 64'd1);
        check("s_imm32", 64'(imm32), 64'hFFFFFFFC);
        check("s_tag",   64'(tag32), 64'h02);
        drive(1'b1, 32'h123450B7, 3'd3, 8'h03);
        step();
        check("u_imm32", 64'(imm32), 64'h12345000);
        check("u_imm64", imm64,      64'h12345000);
        check("u_tag",   64'(tag32), 64'h03);
        drive(1'b1, 32'hFE000EE3, 3'd2, 8'h04);
        step();
        check("b_imm32", 64'(imm32), 64'hFFFFFFFC);
        check("b_imm64", imm64,      64'hFFFFFFFFFFFFFFFC);
        drive(1'b1, 32'hFFDFF06F, 3'd4, 8'h05);
        step();
        check("j_imm32", 64'(imm32), 64'hFFFFFFFC);
        drive(1'b1, 32'h80000037, 3'd3, 8'h06);
        step();
        check("u_neg_imm32", 64'(imm32), 64'h80000000);
        check("u_neg_imm64", imm64,      64'hFFFFFFFF80000000);
        drive(1'b1, 32'h03F01013, 3'd6, 8'h07);
        step();
        check("sh_imm32", 64'(imm32), 64'h1F);
        check("sh_imm64", imm64,      64'h3F);
        drive(1'b1, 32'h000FD073, 3'd5, 8'h08);
        step();
        check("z_imm32", 64'(imm32), 64'h1F);
        check("z_err32", 64'(err32), 64'd0);
        drive(1'b1, 32'hFFFFFFFF, 3'd7, 8'h09);
        step();
        check("ill_vld",   64'(vld32), 64'd1);
        check("ill_imm32", 64'(imm32), 64'd0);
        check("ill_err32", 64'(err32), 64'd1);
        check("ill_imm64", imm64,      64'd0);
        check("ill_err64", 64'(err64), 64'd1);
        drive(1'b0, 32'h0, 3'd0, 8'h00);
        step();
        check("drain_vld", 64'(vld32), 64'd0);

        // Backpressure: tags 1,2 fill OUT and SKID, tag 3 must be held off.
        out_ready = 1'b0;
        drive(1'b1, 32'h00100093, 3'd0, 8'h01);
        step();
        check("bp1_tag", 64'(tag32), 64'h01);
        check("bp1_rdy", 64'(rdy32), 64'd1);
        drive(1'b1, 32'h00200093, 3'd0, 8'h02);
        step();
        check("bp2_rdy", 64'(rdy32), 64'd0);
        check("bp2_tag", 64'(tag32), 64'h01);
        drive(1'b1, 32'h00300093, 3'd0, 8'h03);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold_tag", 64'(tag32), 64'h01);
            check("bp_hold_imm", 64'(imm32), 64'h1);
            check("bp_hold_rdy", 64'(rdy64), 64'd0);
        end
        out_ready = 1'b1;
        step();
        check("rel_tag2", 64'(tag32), 64'h02);
        check("rel_imm2", 64'(imm32), 64'h2);
        check("rel_rdy",  64'(rdy32), 64'd1);
        step();
        drive(1'b0, 32'h0, 3'd0, 8'h00);
        check("rel_tag3", 64'(tag64), 64'h03);
        check("rel_imm3", imm64,      64'h3);
        step();
        check("rel_empty", 64'(vld32), 64'd0);

        // Flush with both entries full and a new input offered.
        out_ready = 1'b0;
        drive(1'b1, 32'h01100093, 3'd0, 8'h11);
        step();
        drive(1'b1, 32'h01200093, 3'd0, 8'h12);
        step();
        check("fl_full_rdy", 64'(rdy32), 64'd0);
        drive(1'b1, 32'h01300093, 3'd0, 8'h13);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 3'd0, 8'h00);
        check("fl_vld", 64'(vld32), 64'd0);
        check("fl_rdy", 64'(rdy32), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("fl_gone", 64'(vld32 | vld64), 64'd0);
        end

        // Flush drops an input offered while ready and empty.
        drive(1'b1, 32'h01400093, 3'd0, 8'h14);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 3'd0, 8'h00);
        check("fl_drop_vld", 64'(vld32), 64'd0);

        // Reset mid-backpressure, then the first input after release.
        out_ready = 1'b0;
        drive(1'b1, 32'h02100093, 3'd0, 8'h21);
        step();
        drive(1'b1, 32'h02200093, 3'd0, 8'h22);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_state("midrst");
        out_ready = 1'b1;
        drive(1'b1, 32'h00500093, 3'd0, 8'h31);
        step();
        drive(1'b0, 32'h0, 3'd0, 8'h00);
        check("post_rst_vld", 64'(vld32), 64'd1);
        check("post_rst_tag", 64'(tag32), 64'h31);
        check("post_rst_imm", imm64,      64'h5);
        step();
        check("post_rst_empty", 64'(vld32), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
